imem_boot_arb: RTL and testbench

Boot-load sequencer and access arbiter for the single-cycle ARM instruction memory. After reset it holds the core in stall while a word stream from the host loader fills the RAM from word 0. It then hands the read port to the core's fetch path. A later reload request re-enters load mode without a core reset. It sits between the loader or UART front end, the core's PC/Instr fetch path and an internal async-read RAM.

---
 rtl/imem_pkg.sv | 7 +
 rtl/imem_ram.sv | 20 ++
 rtl/imem_boot_arb.sv | 100 ++++++++++
 tb/tb_imem_boot_arb.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory boot loader and arbiter.
package imem_pkg;
  typedef enum logic {LOAD = 1'b0, RUN = 1'b1} boot_state_t;

  localparam logic [31:0] NOP_INSTR  = 32'hE1A00000;
  localparam int          IMEM_DEPTH = 64;
endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: DEPTH x 32, synchronous write, asynchronous read through one shared address.
// With BOOT_LOAD=0 the contents are expected to come from the device's memory initialisation.
module imem_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/imem_boot_arb.sv
// Boot-load sequencer: fills the instruction RAM from a loader stream while stalling the core,
// then hands the RAM read port to the fetch path until a reload is requested.
module imem_boot_arb
  import imem_pkg::*;
#(
  parameter int          DEPTH     = IMEM_DEPTH,
  parameter int          AW        = $clog2(DEPTH),
  parameter bit          BOOT_LOAD = 1'b1,
  parameter logic [31:0] NOP       = NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  input  logic        boot_req,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  output logic        cpu_stall,
  output logic        fetch_fault,
  output logic        load_done,
  output logic        load_err,
  output logic [AW:0] word_count
);
  localparam boot_state_t RST_STATE = BOOT_LOAD ? LOAD : RUN;
  localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);

  boot_state_t   state, state_nxt;
  logic          hs, in_range, ram_we, addr_fault;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic          unused_pc_lsb;

  assign hs            = ld_valid & ld_ready;
  assign in_range      = word_count < DEPTH_W;
  assign ram_we        = hs & in_range;
  assign addr_fault    = |pc[31:AW+2];
  assign unused_pc_lsb = ^pc[1:0];
  // One RAM port: the loader owns the address in LOAD, the fetch path in RUN.
  assign ram_addr      = (state == LOAD) ? word_count[AW-1:0] : pc[AW+1:2];

  imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ld_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= RST_STATE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (hs && ld_last) state_nxt = RUN;
      RUN:     if (boot_req)      state_nxt = LOAD;
      default: state_nxt = RST_STATE;
    endcase
  end

  always_comb begin
    ld_ready    = 1'b0;
    cpu_stall   = 1'b0;
    fetch_fault = 1'b0;
    instr       = NOP;
    case (state)
      LOAD: begin
        ld_ready  = 1'b1;
        cpu_stall = 1'b1;
      end
      RUN: begin
        fetch_fault = addr_fault;
        instr       = addr_fault ? NOP : ram_rdata;
      end
      default: ;
    endcase
  end

  // Overflow words are still accepted so the loader never stalls; the count saturates.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_count <= '0;
      load_err   <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      load_done <= hs & ld_last;
      if (state == RUN && boot_req) begin
        word_count <= '0;
        load_err   <= 1'b0;
      end else if (hs) begin
        if (in_range) word_count <= word_count + 1'b1;
        else          load_err   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imem_boot_arb.sv
// Randomised self-checking bench for imem_boot_arb against a word-level reference model.
module tb_imem_boot_arb;
  localparam logic [31:0] NOP_W = 32'hE1A00000;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        ld_valid = 1'b0, ld_last = 1'b0, boot_req = 1'b0;
  logic [31:0] ld_data = '0, pc = '0;
  logic        ld_ready, cpu_stall, fetch_fault, load_done, load_err;
  logic [31:0] instr;
  logic [6:0]  word_count;

  imem_boot_arb dut (
    .clk(clk), .reset_n(reset_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .boot_req(boot_req), .pc(pc),
    .instr(instr), .cpu_stall(cpu_stall), .fetch_fault(fetch_fault),
    .load_done(load_done), .load_err(load_err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Reference model: image contents plus loader bookkeeping.
  logic [31:0] ref_mem [64];
  int          ref_wc   = 0;
  bit          ref_err  = 0, ref_run = 0, ref_done = 0;

  task automatic model_reset();
    ref_wc = 0; ref_err = 0; ref_run = 0; ref_done = 0;
  endtask

  // One clock of stimulus; inputs change and outputs are sampled on the falling edge.
  task automatic cycle(input bit v, input logic [31:0] d, input bit last, input bit boot);
    ld_valid = v; ld_data = d; ld_last = last; boot_req = boot;
    @(posedge clk);
    ref_done = 0;
    if (!ref_run) begin
      if (v) begin
        if (ref_wc < 64) begin ref_mem[ref_wc] = d; ref_wc = ref_wc + 1; end
        else ref_err = 1;
        if (last) begin ref_run = 1; ref_done = 1; end
      end
    end else if (boot) begin
      ref_run = 0; ref_wc = 0; ref_err = 0;
    end
    @(negedge clk);
    ld_valid = 0; ld_last = 0; boot_req = 0;
  endtask

  task automatic test_reset();
    reset_n = 0; pc = 32'h0000_1000;
    @(negedge clk);
    n_tests++; if (cpu_stall !== 1'b1) begin n_fail++; $display("FAIL reset_stall got %0b exp 1", cpu_stall); end
    n_tests++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %0b exp 1", ld_ready); end
    n_tests++; if (word_count !== 7'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", word_count); end
    n_tests++; if (load_err !== 1'b0 || load_done !== 1'b0) begin n_fail++; $display("FAIL reset_flags got err=%0b done=%0b exp 0/0", load_err, load_done); end
    n_tests++; if (instr !== NOP_W || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL reset_instr got %h/%0b exp %h/0", instr, fetch_fault, NOP_W); end
    reset_n = 1; model_reset();
    @(negedge clk);
  endtask

  task automatic test_boot_load();
    logic [31:0] w [3];
    w[0] = 32'hE3A01001; w[1] = 32'hE3A020FF; w[2] = 32'hE2833004;
    for (int i = 0; i < 3; i++) begin
      pc = $urandom;
      n_tests++; if (cpu_stall !== 1'b1 || instr !== NOP_W || fetch_fault !== 1'b0) begin n_fail++; $display("FAIL boot_stall[%0d] got stall=%0b instr=%h fault=%0b exp 1/%h/0", i, cpu_stall, instr, fetch_fault, NOP_W); end
      cycle(1, w[i], i == 2, 0);
    end
    n_tests++; if (load_done !== 1'b1 || cpu_stall !== 1'b0 || ld_ready !== 1'b0) begin n_fail++; $display("FAIL boot_done got done=%0b stall=%0b ready=%0b exp 1/0/0", load_done, cpu_stall, ld_ready); end
    n_tests++; if (word_count !== 7'd3) begin n_fail++; $display("FAIL boot_count got %0d exp 3", word_count); end
    cycle(0, 0, 0, 0);
    n_tests++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL boot_done_pulse got %0b exp 0", load_done); end
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4); @(negedge clk);
      n_tests++; if (instr !== w[i]) begin n_fail++; $display("FAIL boot_fetch[%0d] got %h exp %h", i, instr, w[i]); end
    end
  endtask

  task automatic test_gaps();
    logic [31:0] w [3];
    bit v [5] = '{1, 0, 1, 0, 1};
    int k = 0;
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    cycle(0, 0, 0, 1);
    n_tests++; if (cpu_stall !== 1'b1 || word_count !== 7'd0) begin n_fail++; $display("FAIL gaps_reload got stall=%0b count=%0d exp 1/0", cpu_stall, word_count); end
    for (int c = 0; c < 5; c++) begin
      // boot_req during a gap cycle is a LOAD-state request and must be ignored
      cycle(v[c], v[c] ? w[k] : 32'hDEAD_BEEF, c == 4, c == 1);
      if (v[c]) k++;
      n_tests++; if (word_count !== 7'(ref_wc)) begin n_fail++; $display("FAIL gaps_count[%0d] got %0d exp %0d", c, word_count, ref_wc); end
    end
    n_tests++; if (word_count !== 7'd3 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL gaps_end got count=%0d stall=%0b exp 3/0", word_count, cpu_stall); end
    for (int i = 0; i < 3; i++) begin
      pc = 32'(i * 4); @(negedge clk);
      n_tests++; if (instr !== w[i]) begin n_fail++; $display("FAIL gaps_fetch[%0d] got %h exp %h", i, instr, w[i]); end
    end
  endtask

  task automatic test_out_of_range();
    int sent = 0;
    cycle(0, 0, 0, 1);
    while (sent < 64) begin
      bit v = ($urandom_range(0, 3) != 0);
      cycle(v, $urandom, v && sent == 63, 0);
      if (v) sent++;
    end
    n_tests++; if (word_count !== 7'd64 || load_err !== 1'b0) begin n_fail++; $display("FAIL oor_fill got count=%0d err=%0b exp 64/0", word_count, load_err); end
    pc = 32'h0000_0100; @(negedge clk);
    n_tests++; if (fetch_fault !== 1'b1 || instr !== NOP_W) begin n_fail++; $display("FAIL oor_100 got fault=%0b instr=%h exp 1/%h", fetch_fault, instr, NOP_W); end
    pc = 32'h0000_00FC; @(negedge clk);
    n_tests++; if (fetch_fault !== 1'b0 || instr !== ref_mem[63]) begin n_fail++; $display("FAIL oor_0fc got fault=%0b instr=%h exp 0/%h", fetch_fault, instr, ref_mem[63]); end
    for (int i = 0; i < 40; i++) begin
      logic [31:0] exp_i;
      bit          exp_f;
      pc = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : $urandom;
      exp_f = (pc >= 32'd256);
      exp_i = exp_f ? NOP_W : ref_mem[pc[7:2]];
      @(negedge clk);
      n_tests++; if (fetch_fault !== exp_f || instr !== exp_i) begin n_fail++; $display("FAIL oor_rand pc=%h got %0b/%h exp %0b/%h", pc, fetch_fault, instr, exp_f, exp_i); end
    end
  endtask

  task automatic test_overflow();
    cycle(0, 0, 0, 1);
    for (int i = 1; i <= 66; i++) begin
      cycle(1, 32'hA000_0000 + 32'(i), i == 66, 0);
      if (i == 64) begin
        n_tests++; if (load_err !== 1'b0 || word_count !== 7'd64) begin n_fail++; $display("FAIL ovf_64 got err=%0b count=%0d exp 0/64", load_err, word_count); end
      end
      if (i == 65) begin
        n_tests++; if (load_err !== 1'b1 || word_count !== 7'd64 || cpu_stall !== 1'b1) begin n_fail++; $display("FAIL ovf_65 got err=%0b count=%0d stall=%0b exp 1/64/1", load_err, word_count, cpu_stall); end
      end
    end
    n_tests++; if (load_err !== 1'b1 || word_count !== 7'd64 || cpu_stall !== 1'b0 || load_done !== 1'b1) begin n_fail++; $display("FAIL ovf_end got err=%0b count=%0d stall=%0b done=%0b exp 1/64/0/1", load_err, word_count, cpu_stall, load_done); end
    for (int i = 0; i < 64; i++) begin
      pc = 32'(i * 4); @(negedge clk);
      n_tests++; if (instr !== 32'hA000_0000 + 32'(i + 1)) begin n_fail++; $display("FAIL ovf_fetch[%0d] got %h exp %h", i, instr, 32'hA000_0000 + 32'(i + 1)); end
    end
  endtask

  task automatic test_reload();
    cycle(0, 0, 0, 1);
    n_tests++; if (cpu_stall !== 1'b1 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL reload_stall got stall=%0b ready=%0b exp 1/1", cpu_stall, ld_ready); end
    n_tests++; if (word_count !== 7'd0 || load_err !== 1'b0) begin n_fail++; $display("FAIL reload_clear got count=%0d err=%0b exp 0/0", word_count, load_err); end
    cycle(1, 32'hE3A00005, 1, 0);
    pc = 32'h0; @(negedge clk);
    n_tests++; if (instr !== 32'hE3A00005) begin n_fail++; $display("FAIL reload_w0 got %h exp E3A00005", instr); end
    pc = 32'h4; @(negedge clk);
    n_tests++; if (instr !== 32'hA000_0002) begin n_fail++; $display("FAIL reload_w1 got %h exp A0000002", instr); end
  endtask

  task automatic test_reset_mid_load();
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    cycle(0, 0, 0, 1);
    cycle(1, 32'h1111_1111, 0, 0);
    cycle(1, 32'h2222_2222, 0, 0);
    reset_n = 0; #2;
    n_tests++; if (word_count !== 7'd0 || cpu_stall !== 1'b1 || ld_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_state got count=%0d stall=%0b ready=%0b exp 0/1/1", word_count, cpu_stall, ld_ready); end
    n_tests++; if (load_done !== 1'b0 || load_err !== 1'b0 || instr !== NOP_W) begin n_fail++; $display("FAIL midrst_flags got done=%0b err=%0b instr=%h exp 0/0/%h", load_done, load_err, instr, NOP_W); end
    @(negedge clk); reset_n = 1; model_reset(); @(negedge clk);
    for (int i = 0; i < 4; i++) cycle(1, w[i], i == 3, 0);
    n_tests++; if (load_done !== 1'b1 || word_count !== 7'd4 || cpu_stall !== 1'b0) begin n_fail++; $display("FAIL midrst_done got done=%0b count=%0d stall=%0b exp 1/4/0", load_done, word_count, cpu_stall); end
    for (int i = 0; i < 5; i++) begin
      logic [31:0] e = (i < 4) ? w[i] : 32'hA000_0005;
      pc = 32'(i * 4); @(negedge clk);
      n_tests++; if (instr !== e) begin n_fail++; $display("FAIL midrst_fetch[%0d] got %h exp %h", i, instr, e); end
    end
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 70);
      int sent = 0;
      cycle(0, 0, 0, 1);
      while (sent < n) begin
        bit v = ($urandom_range(0, 3) != 0);
        cycle(v, $urandom, v && sent == n - 1, $urandom_range(0, 7) == 0);
        if (v) sent++;
        n_tests++;
        if (word_count !== 7'(ref_wc) || load_err !== ref_err || load_done !== ref_done || cpu_stall !== !ref_run) begin
          n_fail++; $display("FAIL b2b[%0d] got count=%0d err=%0b done=%0b stall=%0b exp %0d/%0b/%0b/%0b", r, word_count, load_err, load_done, cpu_stall, ref_wc, ref_err, ref_done, !ref_run);
        end
      end
      for (int i = 0; i < 16; i++) begin
        pc = 32'($urandom_range(0, 255)); @(negedge clk);
        n_tests++; if (instr !== ref_mem[pc[7:2]]) begin n_fail++; $display("FAIL b2b_fetch pc=%h got %h exp %h", pc, instr, ref_mem[pc[7:2]]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_boot_load();
    test_gaps();
    test_out_of_range();
    test_overflow();
    test_reload();
    test_reset_mid_load();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
